fpu_wb_buffer: RTL and testbench

Result buffer placed directly downstream of the FPU wrapper. The FPU output is a single-cycle valid pulse with no back-pressure, so every pulse is captured here into a small FIFO. Entries are presented to the writeback/scoreboard port under a valid/ready handshake. The block accumulates committed FP exception flags (fflags), and raises an early stall so issue logic can stop feeding the FPU before the buffer fills.

---
 rtl/fpu_wb_buffer_if.sv | 39 +++
 rtl/fpu_wb_buffer.sv | 122 ++++++++++++
 tb/tb_fpu_wb_buffer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_wb_buffer_if.sv
// Purpose: bundles the FPU result input and writeback output of fpu_wb_buffer.
// Latency: wires only; the bundle adds no registers and no delay.
// Backpressure: the FPU side has none; the wb side uses wb_valid_o/wb_ready_i, and stall_o is an early hint to issue.
// Ports: master = FPU/issue/writeback environment side, slave = the buffer itself.
interface fpu_wb_buffer_if #(
  parameter int FLEN          = 64,
  parameter int TRANS_ID_BITS = 3
);
  logic                     flush_i;
  logic                     fpu_valid_i;
  logic [TRANS_ID_BITS-1:0] fpu_trans_id_i;
  logic [FLEN-1:0]          fpu_result_i;
  logic [4:0]               fpu_fflags_i;
  logic                     fpu_ex_valid_i;
  logic                     stall_o;
  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [FLEN-1:0]          wb_result_o;
  logic [4:0]               wb_fflags_o;
  logic                     wb_ex_valid_o;
  logic                     fflags_clr_i;
  logic [4:0]               fflags_acc_o;
  logic                     overflow_o;

  modport master (
    output flush_i, fpu_valid_i, fpu_trans_id_i, fpu_result_i, fpu_fflags_i,
           fpu_ex_valid_i, wb_ready_i, fflags_clr_i,
    input  stall_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_fflags_o,
           wb_ex_valid_o, fflags_acc_o, overflow_o
  );

  modport slave (
    input  flush_i, fpu_valid_i, fpu_trans_id_i, fpu_result_i, fpu_fflags_i,
           fpu_ex_valid_i, wb_ready_i, fflags_clr_i,
    output stall_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_fflags_o,
           wb_ex_valid_o, fflags_acc_o, overflow_o
  );
endinterface

// File: rtl/fpu_wb_buffer.sv
// Purpose: captures every FPU result pulse into a circular FIFO and presents it to writeback; accumulates popped fflags.
// Latency: a result captured at edge N is visible on wb_* after edge N (one cycle); no same-cycle bypass.
// Backpressure: FPU side cannot be stalled, so stall_o rises at DEPTH-SKID entries; a push into a full buffer with no pop is dropped and flagged.
// Ports: clk_i/rst_i (sync, active-high) plain; everything else through fpu_wb_buffer_if.slave:
//   fpu_* result input, wb_* valid/ready head output, flush_i, fflags_clr_i/fflags_acc_o, stall_o, overflow_o.
module fpu_wb_buffer #(
  parameter int DEPTH         = 4,
  parameter int SKID          = 2,
  parameter int FLEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fpu_wb_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID);

  // Storage array: deliberately not reset; count_q alone decides validity.
  logic [TRANS_ID_BITS-1:0] id_mem  [DEPTH];
  logic [FLEN-1:0]          res_mem [DEPTH];
  logic [4:0]               ff_mem  [DEPTH];
  logic                     ex_mem  [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    fflags_acc_q, fflags_acc_d;
  logic          overflow_q, overflow_d;

  logic wb_valid;
  logic full;
  logic push;
  logic pop;
  logic push_ok;
  logic drop;

  always_comb begin
    wb_valid = (count_q != '0);
    full     = (count_q == FULL_CNT);
    push     = bus.fpu_valid_i & ~bus.flush_i;
    pop      = wb_valid & bus.wb_ready_i & ~bus.flush_i;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push_ok  = push & (~full | pop);
    drop     = push & full & ~pop;
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fflags_acc_d = fflags_acc_q;
    overflow_d   = overflow_q | drop;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flush empties the FIFO; push/pop are already masked by flush_i above.
    if (bus.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    // A clear coinciding with a pop keeps the popped entry's flags, since
    // that instruction commits after the CSR write.
    if (pop) begin
      fflags_acc_d = bus.fflags_clr_i ? ff_mem[rd_ptr_q]
                                      : (fflags_acc_q | ff_mem[rd_ptr_q]);
    end else if (bus.fflags_clr_i) begin
      fflags_acc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fflags_acc_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fflags_acc_q <= fflags_acc_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      id_mem[wr_ptr_q]  <= bus.fpu_trans_id_i;
      res_mem[wr_ptr_q] <= bus.fpu_result_i;
      ff_mem[wr_ptr_q]  <= bus.fpu_fflags_i;
      ex_mem[wr_ptr_q]  <= bus.fpu_ex_valid_i;
    end
  end

  // All outputs come from registered state only.
  always_comb begin
    bus.wb_valid_o    = wb_valid;
    bus.wb_trans_id_o = id_mem[rd_ptr_q];
    bus.wb_result_o   = res_mem[rd_ptr_q];
    bus.wb_fflags_o   = ff_mem[rd_ptr_q];
    bus.wb_ex_valid_o = ex_mem[rd_ptr_q];
    bus.stall_o       = (count_q >= STALL_CNT);
    bus.fflags_acc_o  = fflags_acc_q;
    bus.overflow_o    = overflow_q;
  end
endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Purpose: self-checking bench for fpu_wb_buffer with a scoreboard queue and an independent monitor.
// Latency: expects one-cycle push-to-output latency and one entry per cycle throughput.
// Backpressure: drives wb_ready_i directly; expects stall_o at 2 of 4 entries and sticky overflow_o on a dropped push.
module tb_fpu_wb_buffer;
  localparam int DEPTH = 4;
  localparam int SKID  = 2;
  localparam int FLEN  = 64;
  localparam int TIDB  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_wb_buffer_if #(.FLEN(FLEN), .TRANS_ID_BITS(TIDB)) bus ();

  fpu_wb_buffer #(
    .DEPTH(DEPTH), .SKID(SKID), .FLEN(FLEN), .TRANS_ID_BITS(TIDB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] res;
    logic [4:0]  ff;
    logic        ex;
  } ent_t;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.fpu_valid_i  = 1'b0;
    bus.flush_i      = 1'b0;
    bus.fflags_clr_i = 1'b0;
  endtask

  task automatic push(input logic [2:0] id, input logic [63:0] res, input logic [4:0] ff,
                      input logic ex, input bit accept);
    bus.fpu_valid_i    = 1'b1;
    bus.fpu_trans_id_i = id;
    bus.fpu_result_i   = res;
    bus.fpu_fflags_i   = ff;
    bus.fpu_ex_valid_i = ex;
    if (accept) exp_q.push_back({id, res, ff, ex});
  endtask

  // Monitor: mid-cycle, a visible handshake will be consumed at the next edge.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && bus.wb_valid_o === 1'b1 && bus.wb_ready_i === 1'b1 && bus.flush_i === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_pop_unexpected: got id %0d, expected no entry", bus.wb_trans_id_o);
      end else begin
        e = exp_q.pop_front();
        chk("wb_entry", {bus.wb_trans_id_o, bus.wb_result_o, bus.wb_fflags_o, bus.wb_ex_valid_o}, e);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.wb_ready_i = 1'b0;
    bus.fpu_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.fflags_clr_i = 1'b0;
    bus.fpu_trans_id_i = '0;
    bus.fpu_result_i = '0;
    bus.fpu_fflags_i = '0;
    bus.fpu_ex_valid_i = 1'b0;

    // Reset with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.fpu_valid_i    = 1'($urandom);
      bus.flush_i        = 1'($urandom);
      bus.fflags_clr_i   = 1'($urandom);
      bus.wb_ready_i     = 1'($urandom);
      bus.fpu_trans_id_i = 3'($urandom);
      bus.fpu_result_i   = {$urandom, $urandom};
      bus.fpu_fflags_i   = 5'($urandom);
      bus.fpu_ex_valid_i = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_wb_valid", bus.wb_valid_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_fflags_acc", bus.fflags_acc_o, 0);
    chk("rst_overflow", bus.overflow_o, 0);
    rst = 1'b0;
    bus.fpu_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.fflags_clr_i = 1'b0;
    bus.wb_ready_i = 1'b0;

    // First entry after reset, one-cycle latency.
    push(3'd3, 64'h3FF0_0000_0000_0000, 5'b00001, 1'b0, 1);
    step();
    chk("first_valid", bus.wb_valid_o, 1);
    chk("first_id", bus.wb_trans_id_o, 3);
    chk("first_result", bus.wb_result_o, 64'h3FF0_0000_0000_0000);
    chk("first_fflags", bus.wb_fflags_o, 5'b00001);
    bus.wb_ready_i = 1'b1;
    step();
    chk("first_acc", bus.fflags_acc_o, 5'b00001);
    chk("first_empty", bus.wb_valid_o, 0);
    bus.wb_ready_i = 1'b0;

    // Order, stall threshold and pointer wrap.
    for (int r = 0; r < 3; r++) begin
      push(3'd0, 64'h1000 + 64'(r), 5'b0, 1'b0, 1);
      step();
      chk("wrap_stall_at1", bus.stall_o, 0);
      push(3'd1, 64'h2000 + 64'(r), 5'b0, 1'b1, 1);
      step();
      chk("wrap_stall_at2", bus.stall_o, 1);
      push(3'd2, 64'h3000 + 64'(r), 5'b0, 1'b0, 1);
      step();
      push(3'd3, 64'h4000 + 64'(r), 5'b0, 1'b1, 1);
      step();
      chk("wrap_full_valid", bus.wb_valid_o, 1);
      chk("wrap_full_overflow", bus.overflow_o, 0);
      bus.wb_ready_i = 1'b1;
      repeat (4) step();
      chk("wrap_drained", bus.wb_valid_o, 0);
      chk("wrap_stall_drained", bus.stall_o, 0);
      bus.wb_ready_i = 1'b0;
    end
    chk("wrap_acc_kept", bus.fflags_acc_o, 5'b00001);

    // Full buffer: push with pop accepted, push without pop dropped.
    for (int i = 0; i < 4; i++) begin
      push(3'(i), 64'hF000 + 64'(i), 5'b0, 1'b0, 1);
      step();
    end
    chk("full_stall", bus.stall_o, 1);
    bus.wb_ready_i = 1'b1;
    push(3'd5, 64'hF005, 5'b0, 1'b0, 1);
    step();
    bus.wb_ready_i = 1'b0;
    chk("full_pushpop_overflow", bus.overflow_o, 0);
    chk("full_pushpop_valid", bus.wb_valid_o, 1);
    push(3'd6, 64'hF006, 5'b0, 1'b0, 0);
    step();
    chk("full_drop_overflow", bus.overflow_o, 1);
    bus.wb_ready_i = 1'b1;
    repeat (3) step();
    chk("full_three_left_one", bus.wb_valid_o, 1);
    step();
    chk("full_drained", bus.wb_valid_o, 0);
    chk("overflow_sticky", bus.overflow_o, 1);
    bus.wb_ready_i = 1'b0;

    // Flush with 3 entries, a same-cycle push and wb_ready_i high.
    for (int i = 0; i < 3; i++) begin
      push(3'(i), 64'hE000 + 64'(i), 5'b11111, 1'b1, 1);
      step();
    end
    chk("flush_pre_stall", bus.stall_o, 1);
    push(3'd7, 64'hE007, 5'b11111, 1'b0, 0);
    bus.flush_i = 1'b1;
    bus.wb_ready_i = 1'b1;
    exp_q.delete();
    step();
    bus.wb_ready_i = 1'b0;
    chk("flush_valid", bus.wb_valid_o, 0);
    chk("flush_stall", bus.stall_o, 0);
    chk("flush_acc", bus.fflags_acc_o, 5'b00001);
    chk("flush_overflow", bus.overflow_o, 1);
    push(3'd4, 64'hD004, 5'b0, 1'b0, 1);
    step();
    chk("post_flush_id", bus.wb_trans_id_o, 4);
    chk("post_flush_result", bus.wb_result_o, 64'hD004);
    bus.wb_ready_i = 1'b1;
    step();
    bus.wb_ready_i = 1'b0;

    // fflags clear and accumulate.
    bus.fflags_clr_i = 1'b1;
    step();
    chk("clr_alone_a", bus.fflags_acc_o, 5'b00000);
    push(3'd1, 64'hC001, 5'b10000, 1'b1, 1);
    step();
    push(3'd2, 64'hC002, 5'b00100, 1'b1, 1);
    step();
    bus.wb_ready_i = 1'b1;
    step();
    chk("acc_first", bus.fflags_acc_o, 5'b10000);
    step();
    chk("acc_second", bus.fflags_acc_o, 5'b10100);
    bus.wb_ready_i = 1'b0;
    push(3'd3, 64'hC003, 5'b00010, 1'b0, 1);
    step();
    bus.wb_ready_i = 1'b1;
    bus.fflags_clr_i = 1'b1;
    step();
    chk("clr_with_pop", bus.fflags_acc_o, 5'b00010);
    bus.wb_ready_i = 1'b0;
    bus.fflags_clr_i = 1'b1;
    step();
    chk("clr_alone_b", bus.fflags_acc_o, 5'b00000);

    // Reset clears sticky overflow before the throughput run.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("rerst_overflow", bus.overflow_o, 0);
    chk("rerst_valid", bus.wb_valid_o, 0);

    // Back-to-back: one push and one pop per cycle.
    bus.wb_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(3'(i % 8), 64'hB000 + 64'(i), 5'(i), 1'(i % 2), 1);
      step();
      chk("b2b_valid", bus.wb_valid_o, 1);
      chk("b2b_stall", bus.stall_o, 0);
      chk("b2b_overflow", bus.overflow_o, 0);
    end
    step();
    chk("b2b_drained", bus.wb_valid_o, 0);
    bus.wb_ready_i = 1'b0;
    step();

    chk("scoreboard_empty", 128'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
